mfp_ram_stream_reader: RTL
==========================

# mfp_ram_stream_reader

Streams a contiguous block of words out of the read port of the SoC's synchronous dual-port RAM onto a valid/ready stream interface. It consumes the RAM's one-cycle registered read latency and hides it behind a small output FIFO, so a downstream consumer (UART TX serializer, display/pixel feeder) gets one word per cycle while it holds ready high. A transfer is launched by a one-cycle start pulse carrying a base address and a word count.

## Interface
- ADDR_WIDTH, 10, RAM word-address width; the address space is 2^ADDR_WIDTH words.
- DATA_WIDTH, 16, RAM and stream word width.
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle launch pulse; ignored while busy.
- base_addr  in  ADDR_WIDTH  first word address, sampled with start.
- length  in  ADDR_WIDTH+1  word count, 0..2^ADDR_WIDTH, sampled with start.
- busy  out  1  a transfer is in progress.
- done  out  1  one-cycle pulse at transfer completion.
- read_addr  out  ADDR_WIDTH  registered address to the RAM read port.
- read_data  in  DATA_WIDTH  RAM read data, valid one cycle after read_addr.
- out_valid  out  1  out_data/out_last are valid.
- out_ready  in  1  consumer accepts the word when high together with out_valid.
- out_data  out  DATA_WIDTH  stream word.
- out_last  out  1  marks the final word of the transfer.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: start=1 latches base_addr into addr_ctr and length into issue_cnt and accept_cnt, then moves to RUN. If length=0, the block instead pulses done in the next cycle and stays in IDLE; busy stays low and nothing is emitted.
- RUN: issue one read per cycle when issue_cnt≠0 and (fifo_count + inflight) < 4. An issue registers read_addr←addr_ctr, increments addr_ctr modulo 2^ADDR_WIDTH (wrap from 1023 to 0 is legal) and decrements issue_cnt. When issue_cnt reaches 0, move to DRAIN.
- Two-stage valid pipeline: v1 marks that read_addr was issued; v2 marks that read_data holds that word. When v2=1, read_data is pushed into the FIFO, together with last=1 if it is the final issued word.
- FIFO: 4 entries. The head drives out_data/out_last and out_valid=!empty. A pop occurs on out_valid&&out_ready. Push and pop in the same cycle are legal at any occupancy, including full with a pop. The credit rule makes overflow impossible, and overflow must never occur.
- DRAIN: no issues. Each handshake decrements accept_cnt. The handshake that brings accept_cnt to 0 (the out_last word) sends the block to IDLE, with done=1 in the following cycle.
- busy=1 in RUN and DRAIN and low in IDLE. done and busy are never high together.
- out_data and out_last stay stable while out_valid=1 and out_ready=0.
- start while busy: ignored, with no effect on the current transfer.
- rst at any time, including mid-transfer: next state IDLE; FIFO, v1, v2 and counters cleared; in-flight RAM data discarded; no done pulse.

## Timing
- Reset values: busy=0, done=0, read_addr=0, out_valid=0, out_data=0, out_last=0.
- Start sampled at cycle 0; read_addr=base_addr in cycle 1; read_data valid in cycle 2; out_valid=1 in cycle 3 (first-word latency 3 cycles).
- With out_ready held high, throughput is 1 word/cycle, so N words finish their handshakes in cycles 3..N+2. done=1 in cycle N+3.
- While out_ready is low, issue stops once fifo_count+inflight=4. Issue resumes in the cycle after a pop frees a credit.
- Counter widths: issue_cnt and accept_cnt are ADDR_WIDTH+1 bits, so length=2^ADDR_WIDTH is representable.

## Structure
- Shared header/package mfp_ram_stream_pkg: state encodings (IDLE/RUN/DRAIN), FIFO_DEPTH=4, CNT_WIDTH=ADDR_WIDTH+1.
- One sub-module: mfp_stream_fifo, a 4-deep synchronous FIFO of {last, data} with push/pop/full/empty/count, parameterised on DATA_WIDTH+1.
- Top level holds the FSM, address/count registers, the v1/v2 pipeline and the credit check. It is instantiated next to mfp_dual_port_ram, with read_addr/read_data wired port-to-port.

## Test plan
- RAM preloaded with word=address; base_addr=5, length=4, out_ready=1 → out_data 5,6,7,8 in cycles 3..6, out_last only on 8, done in cycle 7.
- base_addr=1022, length=4 → out_data 1022,1023,0,1 (address wrap).
- length=0 → done one cycle after start, no out_valid, busy stays 0.
- length=16, out_ready toggled randomly with long low stretches → all 16 words in order with no loss or duplication, at most 4 reads ahead, and out_data stable while stalled.
- start pulsed again in mid-transfer → ignored, and the original sequence completes unchanged.
- rst asserted in cycle 4 of a length=10 transfer → all outputs at reset values in the next cycle, no done pulse; a new start then runs cleanly from its own base_addr.

Source files
------------

// File: rtl/mfp_ram_stream_pkg.sv
// rtl/mfp_ram_stream_pkg.sv - shared types and constants for the RAM stream reader
package mfp_ram_stream_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_AW    = 2;             // pointer width for FIFO_DEPTH entries
  localparam int FIFO_CW    = FIFO_AW + 1;   // occupancy width, holds 0..FIFO_DEPTH

  // Counters hold 0..2^aw words, so they need one bit more than the address.
  function automatic int cnt_width(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/mfp_ram_stream_reader_if.sv
// rtl/mfp_ram_stream_reader_if.sv - valid/ready output stream bundle
interface mfp_ram_stream_reader_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  modport master (output out_valid, out_data, out_last, input out_ready);
  modport slave  (input out_valid, out_data, out_last, output out_ready);
endinterface

// File: rtl/mfp_stream_fifo.sv
// rtl/mfp_stream_fifo.sv - 4-deep synchronous FIFO of {last, data} words
module mfp_stream_fifo
  import mfp_ram_stream_pkg::*;
#(
  parameter int WIDTH = 17
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [WIDTH-1:0]   push_data,
  input  logic               pop,
  output logic [WIDTH-1:0]   pop_data,
  output logic               full,
  output logic               empty,
  output logic [FIFO_CW-1:0] count
);

  logic [WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_CW-1:0] cnt;
  logic               do_pop;
  logic               do_push;

  assign full     = (cnt == FIFO_CW'(FIFO_DEPTH));
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign pop_data = mem[rd_ptr];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage, pointers and occupancy; storage is cleared so the head reads 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + FIFO_AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + FIFO_AW'(1);
      cnt <= cnt + FIFO_CW'(do_push) - FIFO_CW'(do_pop);
    end
  end

endmodule

// File: rtl/mfp_ram_stream_reader.sv
// rtl/mfp_ram_stream_reader.sv - streams a block of RAM words onto a valid/ready stream
module mfp_ram_stream_reader
  import mfp_ram_stream_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [DATA_WIDTH-1:0] read_data,
  mfp_ram_stream_reader_if.master out
);

  localparam int CW = cnt_width(ADDR_WIDTH);

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_ctr;
  logic [CW-1:0]         issue_cnt;
  logic [CW-1:0]         accept_cnt;
  logic                  v1;
  logic                  v2;
  logic                  last1;
  logic                  last2;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FIFO_CW-1:0]    fifo_count;
  logic [DATA_WIDTH:0]   head_word;
  logic [FIFO_CW-1:0]    inflight;
  logic                  credit_ok;
  logic                  issue;
  logic                  handshake;

  // Words already read but not yet in the FIFO still hold a FIFO slot in reserve.
  assign inflight  = FIFO_CW'(v1) + FIFO_CW'(v2);
  assign credit_ok = !fifo_full && ((fifo_count + inflight) < FIFO_CW'(FIFO_DEPTH));
  assign issue     = (state == S_RUN) && (issue_cnt != '0) && credit_ok;
  assign handshake = out.out_valid && out.out_ready;
  assign busy      = (state != S_IDLE);

  assign out.out_valid = !fifo_empty;
  assign out.out_data  = head_word[DATA_WIDTH-1:0];
  assign out.out_last  = head_word[DATA_WIDTH];

  mfp_stream_fifo #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (v2),
    .push_data({last2, read_data}),
    .pop      (handshake),
    .pop_data (head_word),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Control FSM, read issue, address/count registers and the read-latency pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      addr_ctr   <= '0;
      issue_cnt  <= '0;
      accept_cnt <= '0;
      read_addr  <= '0;
      v1         <= 1'b0;
      v2         <= 1'b0;
      last1      <= 1'b0;
      last2      <= 1'b0;
      done       <= 1'b0;
    end else begin
      done  <= 1'b0;
      v1    <= 1'b0;
      last1 <= 1'b0;
      v2    <= v1;
      last2 <= last1;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (length == '0) begin
              done <= 1'b1;
            end else begin
              // The start cycle issues the first read so it reaches the RAM one cycle later.
              read_addr  <= base_addr;
              addr_ctr   <= base_addr + ADDR_WIDTH'(1);
              issue_cnt  <= length - CW'(1);
              accept_cnt <= length;
              v1         <= 1'b1;
              last1      <= (length == CW'(1));
              state      <= (length == CW'(1)) ? S_DRAIN : S_RUN;
            end
          end
        end
        S_RUN: begin
          if (issue) begin
            read_addr <= addr_ctr;
            addr_ctr  <= addr_ctr + ADDR_WIDTH'(1);
            issue_cnt <= issue_cnt - CW'(1);
            v1        <= 1'b1;
            last1     <= (issue_cnt == CW'(1));
            if (issue_cnt == CW'(1)) state <= S_DRAIN;
          end
          if (handshake) accept_cnt <= accept_cnt - CW'(1);
        end
        S_DRAIN: begin
          if (handshake) begin
            accept_cnt <= accept_cnt - CW'(1);
            if (accept_cnt == CW'(1)) begin
              state <= S_IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
